bus_guard_arbiter: RTL and testbench



---
 rtl/bus_guard_arbiter_pkg.sv | 23 ++
 rtl/bus_guard_arbiter_rr_pick.sv | 28 ++
 rtl/bus_guard_arbiter.sv | 159 +++++++++++++++
 tb/tb_bus_guard_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_guard_arbiter_pkg.sv
// bus_guard_arbiter_pkg: master indices and arbiter state encodings shared by
// the bus arbiter and its round-robin picker.
package bus_guard_arbiter_pkg;

   localparam int BUS_MASTER_W = 2;

   localparam logic [BUS_MASTER_W-1:0] BUS_MASTER_0 = 2'd0;
   localparam logic [BUS_MASTER_W-1:0] BUS_MASTER_1 = 2'd1;
   localparam logic [BUS_MASTER_W-1:0] BUS_MASTER_2 = 2'd2;
   localparam logic [BUS_MASTER_W-1:0] BUS_MASTER_3 = 2'd3;

   typedef enum logic [1:0] {
      BUS_ARB_IDLE  = 2'd0,
      BUS_ARB_OWN   = 2'd1,
      BUS_ARB_ABORT = 2'd2
   } bus_arb_state_e;

   // one-hot active-high mask for a master index
   function automatic logic [3:0] master_onehot(input logic [BUS_MASTER_W-1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/bus_guard_arbiter_rr_pick.sv
// bus_rr_pick: combinational round-robin picker. Scans last+1, last+2, ...
// (mod 4) and returns the first requesting master.
module bus_rr_pick
   import bus_guard_arbiter_pkg::*;
(
   input  logic [3:0]              req,
   input  logic [BUS_MASTER_W-1:0] last,
   output logic [BUS_MASTER_W-1:0] pick,
   output logic                    valid
);

   logic [BUS_MASTER_W-1:0] idx;

   // walk from the farthest offset down so the nearest requester wins
   always_comb begin
      pick  = last;
      valid = 1'b0;
      idx   = '0;
      for (int i = 4; i >= 1; i--) begin
         idx = last + BUS_MASTER_W'(i);
         if (req[idx]) begin
            pick  = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_guard_arbiter.sv
// bus_guard_arbiter: round-robin arbiter for the four-master bus with
// ownership-hold limiting and a slave-response watchdog.
// Define BUS_ARB_WATCHDOG_EN to build the watchdog and ABORT path; without
// it a pending access waits for ready_ indefinitely and timeout is tied low.
module bus_guard_arbiter
   import bus_guard_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int TIMEOUT  = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m0_req_,
   input  logic                    m1_req_,
   input  logic                    m2_req_,
   input  logic                    m3_req_,
   input  logic                    bus_as_,
   input  logic                    bus_ready_,
   output logic                    m0_grnt_,
   output logic                    m1_grnt_,
   output logic                    m2_grnt_,
   output logic                    m3_grnt_,
   output logic [BUS_MASTER_W-1:0] owner,
   output logic                    busy,
   output logic                    timeout,
   output logic [BUS_MASTER_W-1:0] timeout_owner
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   bus_arb_state_e          state;
   logic [3:0]              grnt_n;
   logic [BUS_MASTER_W-1:0] last;
   logic                    pending;
   logic [HOLD_W-1:0]       hold_cnt;

   logic [3:0]              req, others, pick_req;
   logic [BUS_MASTER_W-1:0] pick;
   logic                    pick_vld;
   logic                    as_lo, rdy_lo, pending_nxt, owner_req;
   logic                    rel, preempt, wd_hit;

   assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign as_lo     = ~bus_as_;
   assign rdy_lo    = ~bus_ready_;
   assign owner_req = req[owner];
   assign others    = req & ~master_onehot(owner);

   // a strobe with ready in the same cycle is a zero-wait access: never pending
   assign pending_nxt = (pending | as_lo) & ~rdy_lo;

   // while owning, the owner is excluded so preemption hands to someone else
   assign pick_req = (state == BUS_ARB_OWN) ? others : req;

   assign rel     = (state == BUS_ARB_OWN) && !owner_req && !pending_nxt;
   assign preempt = (state == BUS_ARB_OWN) && (hold_cnt == HOLD_W'(MAX_HOLD)) &&
                    pick_vld && !pending_nxt;

   assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;

   bus_rr_pick u_pick (
      .req   (pick_req),
      .last  (last),
      .pick  (pick),
      .valid (pick_vld)
   );

`ifdef BUS_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt;

   // ready_ arriving in the limit cycle completes the access instead
   assign wd_hit = (state == BUS_ARB_OWN) && pending && !rdy_lo &&
                   (wd_cnt == WD_W'(TIMEOUT));

   // count cycles spent pending; restart on completion, handoff or abort
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wd_cnt <= '0;
      else if (state != BUS_ARB_OWN || wd_hit || !pending_nxt)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + WD_W'(1);
   end

   // one-cycle abort pulse plus a sticky record of the aborted master
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout       <= 1'b0;
         timeout_owner <= '0;
      end else begin
         timeout <= wd_hit;
         if (wd_hit)
            timeout_owner <= owner;
      end
   end
`else
   assign wd_hit        = 1'b0;
   assign timeout       = 1'b0;
   assign timeout_owner = '0;
`endif

   // arbiter FSM with registered grants, owner and busy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= BUS_ARB_IDLE;
         grnt_n   <= 4'hF;
         owner    <= BUS_MASTER_0;
         last     <= BUS_MASTER_3;
         busy     <= 1'b0;
         pending  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         case (state)
            BUS_ARB_IDLE: begin
               if (pick_vld) begin
                  grnt_n   <= ~master_onehot(pick);
                  owner    <= pick;
                  last     <= pick;
                  busy     <= 1'b1;
                  pending  <= 1'b0;
                  hold_cnt <= '0;
                  state    <= BUS_ARB_OWN;
               end
            end
            BUS_ARB_OWN: begin
               if (wd_hit) begin
                  // last stays on the aborted master: lowest priority next
                  grnt_n   <= 4'hF;
                  busy     <= 1'b0;
                  pending  <= 1'b0;
                  hold_cnt <= '0;
                  state    <= BUS_ARB_ABORT;
               end else if (rel || preempt) begin
                  pending  <= 1'b0;
                  hold_cnt <= '0;
                  if (pick_vld) begin
                     grnt_n <= ~master_onehot(pick);
                     owner  <= pick;
                     last   <= pick;
                  end else begin
                     grnt_n <= 4'hF;
                     busy   <= 1'b0;
                     state  <= BUS_ARB_IDLE;
                  end
               end else begin
                  pending <= pending_nxt;
                  if (hold_cnt != HOLD_W'(MAX_HOLD))
                     hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            BUS_ARB_ABORT: state <= BUS_ARB_IDLE;
            default:       state <= BUS_ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_guard_arbiter.sv
// tb_bus_guard_arbiter: directed tests for bus_guard_arbiter with
// MAX_HOLD = 4 and TIMEOUT = 8. Inputs change and outputs are checked 1ns
// after each rising edge; "cycle N" is the interval after edge N.
module tb_bus_guard_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       m0_req_ = 1'b1, m1_req_ = 1'b1, m2_req_ = 1'b1, m3_req_ = 1'b1;
   logic       bus_as_ = 1'b1, bus_ready_ = 1'b1;
   logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
   logic [1:0] owner, timeout_owner;
   logic       busy, timeout;
   logic [3:0] grnt;

   int vectors = 0;
   int miscompares = 0;

   assign grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

   always #5 clk = ~clk;

   bus_guard_arbiter #(.MAX_HOLD(4), .TIMEOUT(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .m0_req_       (m0_req_),
      .m1_req_       (m1_req_),
      .m2_req_       (m2_req_),
      .m3_req_       (m3_req_),
      .bus_as_       (bus_as_),
      .bus_ready_    (bus_ready_),
      .m0_grnt_      (m0_grnt_),
      .m1_grnt_      (m1_grnt_),
      .m2_grnt_      (m2_grnt_),
      .m3_grnt_      (m3_grnt_),
      .owner         (owner),
      .busy          (busy),
      .timeout       (timeout),
      .timeout_owner (timeout_owner)
   );

   // expected active-low grant bus for master m
   function automatic logic [3:0] gr(input int m);
      logic [3:0] one;
      one = 4'b0001 << m;
      return ~one;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // r is active-high: bit i set means master i requests
   task automatic set_req(input logic [3:0] r);
      {m3_req_, m2_req_, m1_req_, m0_req_} = ~r;
   endtask

   task automatic do_reset();
      set_req(4'h0);
      bus_as_    = 1'b1;
      bus_ready_ = 1'b1;
      reset      = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      vectors++; if (grnt !== 4'hF) begin miscompares++; $display("FAIL reset_grnt got %b want %b", grnt, 4'hF); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (owner !== 2'd0) begin miscompares++; $display("FAIL reset_owner got %0d want 0", owner); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", timeout); end
      vectors++; if (timeout_owner !== 2'd0) begin miscompares++; $display("FAIL reset_tout_owner got %0d want 0", timeout_owner); end
   endtask

   task automatic test_first_grant();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      vectors++; if (grnt !== 4'hF) begin miscompares++; $display("FAIL idle_grnt got %b want %b", grnt, 4'hF); end
      set_req(4'b0100);
      step();
      vectors++; if (grnt !== gr(2)) begin miscompares++; $display("FAIL first_grnt got %b want %b", grnt, gr(2)); end
      vectors++; if (owner !== 2'd2) begin miscompares++; $display("FAIL first_owner got %0d want 2", owner); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL first_busy got %b want 1", busy); end
      set_req(4'h0);
      step();
      vectors++; if (grnt !== 4'hF) begin miscompares++; $display("FAIL first_release_grnt got %b want %b", grnt, 4'hF); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL first_release_busy got %b want 0", busy); end
      vectors++; if (owner !== 2'd2) begin miscompares++; $display("FAIL first_release_owner got %0d want 2", owner); end
   endtask

   task automatic test_rotation();
      logic [3:0] msk;
      do_reset();
      set_req(4'hF);
      step();
      for (int k = 0; k < 5; k++) begin
         vectors++; if (grnt !== gr(k % 4)) begin miscompares++; $display("FAIL rotation_grnt step %0d got %b want %b", k, grnt, gr(k % 4)); end
         vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rotation_busy step %0d got %b want 1", k, busy); end
         // owner does one zero-wait access and drops its request
         msk = 4'b0001 << (k % 4);
         set_req(4'hF & ~msk);
         bus_as_    = 1'b0;
         bus_ready_ = 1'b0;
         step();
      end
      vectors++; if (grnt !== gr(1)) begin miscompares++; $display("FAIL rotation_tail got %b want %b", grnt, gr(1)); end
      set_req(4'h0);
      bus_as_    = 1'b1;
      bus_ready_ = 1'b1;
      step();
      vectors++; if (grnt !== 4'hF) begin miscompares++; $display("FAIL rotation_idle got %b want %b", grnt, 4'hF); end
   endtask

   task automatic test_hold_limit();
      do_reset();
      set_req(4'b0001);
      step();
      set_req(4'b0011);
      bus_as_    = 1'b0;
      bus_ready_ = 1'b0;
      // hold_cnt runs 0..4 over these cycles; preempt is decided at 4
      for (int i = 0; i < 5; i++) begin
         vectors++; if (grnt !== gr(0)) begin miscompares++; $display("FAIL hold_own cycle %0d got %b want %b", i, grnt, gr(0)); end
         step();
      end
      vectors++; if (grnt !== gr(1)) begin miscompares++; $display("FAIL hold_preempt got %b want %b", grnt, gr(1)); end
      vectors++; if (owner !== 2'd1) begin miscompares++; $display("FAIL hold_preempt_owner got %0d want 1", owner); end
   endtask

   task automatic test_hold_pending();
      do_reset();
      set_req(4'b0001);
      step();
      set_req(4'b0011);
      bus_as_    = 1'b0;
      bus_ready_ = 1'b0;
      for (int i = 0; i < 4; i++) step();
      // hold limit reached, but the access started this cycle stays pending
      vectors++; if (grnt !== gr(0)) begin miscompares++; $display("FAIL holdp_limit got %b want %b", grnt, gr(0)); end
      bus_ready_ = 1'b1;
      step();
      bus_as_ = 1'b1;
      vectors++; if (grnt !== gr(0)) begin miscompares++; $display("FAIL holdp_blocked1 got %b want %b", grnt, gr(0)); end
      step();
      vectors++; if (grnt !== gr(0)) begin miscompares++; $display("FAIL holdp_blocked2 got %b want %b", grnt, gr(0)); end
      bus_ready_ = 1'b0;
      step();
      vectors++; if (grnt !== gr(1)) begin miscompares++; $display("FAIL holdp_preempt got %b want %b", grnt, gr(1)); end
      bus_ready_ = 1'b1;
   endtask

`ifdef BUS_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      do_reset();
      set_req(4'b1000);
      step();
      vectors++; if (grnt !== gr(3)) begin miscompares++; $display("FAIL wd_grant got %b want %b", grnt, gr(3)); end
      bus_as_ = 1'b0;
      set_req(4'b1001);
      step();
      bus_as_ = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         vectors++; if (timeout !== 1'b0 || grnt !== gr(3)) begin miscompares++; $display("FAIL wd_wait cycle %0d got timeout=%b grnt=%b want 0 %b", j, timeout, grnt, gr(3)); end
         step();
      end
      vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL wd_pulse got %b want 1", timeout); end
      vectors++; if (timeout_owner !== 2'd3) begin miscompares++; $display("FAIL wd_tout_owner got %0d want 3", timeout_owner); end
      vectors++; if (grnt !== 4'hF) begin miscompares++; $display("FAIL wd_abort_grnt got %b want %b", grnt, 4'hF); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wd_abort_busy got %b want 0", busy); end
      step();
      vectors++; if (timeout !== 1'b0 || grnt !== 4'hF) begin miscompares++; $display("FAIL wd_idle got timeout=%b grnt=%b want 0 1111", timeout, grnt); end
      step();
      vectors++; if (grnt !== gr(0)) begin miscompares++; $display("FAIL wd_regrant got %b want %b", grnt, gr(0)); end
      vectors++; if (timeout_owner !== 2'd3) begin miscompares++; $display("FAIL wd_tout_owner_held got %0d want 3", timeout_owner); end
   endtask
`else
   task automatic test_no_watchdog();
      do_reset();
      set_req(4'b1000);
      step();
      bus_as_ = 1'b0;
      set_req(4'b1001);
      step();
      bus_as_ = 1'b1;
      for (int j = 0; j < 20; j++) step();
      vectors++; if (grnt !== gr(3)) begin miscompares++; $display("FAIL nowd_hold got %b want %b", grnt, gr(3)); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL nowd_timeout got %b want 0", timeout); end
      set_req(4'b0001);
      bus_ready_ = 1'b0;
      step();
      bus_ready_ = 1'b1;
      vectors++; if (grnt !== gr(0)) begin miscompares++; $display("FAIL nowd_handoff got %b want %b", grnt, gr(0)); end
   endtask
`endif

   task automatic test_ready_at_limit();
      do_reset();
      set_req(4'b0100);
      step();
      bus_as_ = 1'b0;
      step();
      bus_as_ = 1'b1;
      for (int j = 1; j < 8; j++) begin
         vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL limit_wait cycle %0d got %b want 0", j, timeout); end
         step();
      end
      // watchdog count is at the limit in this cycle; ready wins
      bus_ready_ = 1'b0;
      set_req(4'h0);
      step();
      bus_ready_ = 1'b1;
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL limit_timeout got %b want 0", timeout); end
      vectors++; if (grnt !== 4'hF || busy !== 1'b0) begin miscompares++; $display("FAIL limit_release got grnt=%b busy=%b want 1111 0", grnt, busy); end
      step();
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL limit_timeout_late got %b want 0", timeout); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(4'b0010);
      step();
      bus_as_ = 1'b0;
      set_req(4'b0011);
      step();
      bus_as_ = 1'b1;
      step();
      step();
      vectors++; if (grnt !== gr(1)) begin miscompares++; $display("FAIL mid_pending got %b want %b", grnt, gr(1)); end
      reset = 1'b1;
      #1;
      vectors++; if (grnt !== 4'hF) begin miscompares++; $display("FAIL mid_async_grnt got %b want %b", grnt, 4'hF); end
      vectors++; if (busy !== 1'b0 || owner !== 2'd0) begin miscompares++; $display("FAIL mid_async_state got busy=%b owner=%0d want 0 0", busy, owner); end
      step();
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL mid_timeout got %b want 0", timeout); end
      reset = 1'b0;
      step();
      vectors++; if (grnt !== gr(0) || owner !== 2'd0) begin miscompares++; $display("FAIL mid_regrant got grnt=%b owner=%0d want %b 0", grnt, owner, gr(0)); end
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_grant();
      test_rotation();
      test_hold_limit();
      test_hold_pending();
`ifdef BUS_ARB_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      test_ready_at_limit();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
